// File: rtl/fft_spec_pkg.sv
// Shared defaults, FSM state type and m_tdata field helpers for the FFT spectrum sink.
package fft_spec_pkg;

   localparam int unsigned NPOINT_DEF = 1024;
   localparam int unsigned DOUT_W_DEF = 16;
   localparam int unsigned PWR_W      = 2 * DOUT_W_DEF + 1;
   localparam int unsigned IDX_W      = $clog2(NPOINT_DEF);

   typedef enum logic [1:0] {StRun, StResync, StCommit} state_e;

   function automatic logic signed [DOUT_W_DEF-1:0] tdata_re(input logic [2*DOUT_W_DEF-1:0] d);
      return d[DOUT_W_DEF-1:0];
   endfunction

   function automatic logic signed [DOUT_W_DEF-1:0] tdata_im(input logic [2*DOUT_W_DEF-1:0] d);
      return d[2*DOUT_W_DEF-1:DOUT_W_DEF];
   endfunction

endpackage

// File: rtl/fft_axis_to_spectrum_if.sv
// AXI-Stream link from the FFT core (master) into the spectrum sink (slave).
interface fft_axis_to_spectrum_if
   import fft_spec_pkg::*;
#(
   parameter int unsigned DOUT_W = DOUT_W_DEF
);
   logic                  m_tvalid;
   logic                  m_tready;
   logic                  m_tlast;
   logic [2*DOUT_W-1:0]   m_tdata;

   modport master (
      output m_tvalid,
      output m_tlast,
      output m_tdata,
      input  m_tready
   );

   modport slave (
      input  m_tvalid,
      input  m_tlast,
      input  m_tdata,
      output m_tready
   );
endinterface

// File: rtl/spectrum_pingpong_ram.sv
// Two-bank simple dual-port RAM; bank select on each side, registered synchronous read.
module spectrum_pingpong_ram
   import fft_spec_pkg::*;
#(
   parameter int unsigned Depth = NPOINT_DEF,
   parameter int unsigned Width = PWR_W,
   localparam int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  logic             wr_bank_i,
   input  logic [AddrW-1:0] wr_addr_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic             rd_bank_i,
   input  logic [AddrW-1:0] rd_addr_i,
   output logic [Width-1:0] rd_data_o
);

   logic [Width-1:0] mem_q [2*Depth];
   logic [Width-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_axis_to_spectrum.sv
// FFT output sink: per-bin power into a ping-pong buffer, frames published on clean tlast.
// Optional PEAK_DETECT_EN adds per-frame peak power/index outputs latched on frame_done.
module fft_axis_to_spectrum
   import fft_spec_pkg::*;
#(
   parameter int unsigned NPOINT = NPOINT_DEF,
   parameter int unsigned DOUT_W = DOUT_W_DEF,
   localparam int unsigned PwrW  = 2 * DOUT_W + 1,
   localparam int unsigned IdxW  = $clog2(NPOINT),
   localparam int unsigned ProdW = 2 * DOUT_W
) (
   input  logic                  sys_clk,
   input  logic                  sys_rstn,
   fft_axis_to_spectrum_if.slave s_axis,
   input  logic                  rd_hold,
   input  logic [IdxW-1:0]       rd_addr,
   output logic [PwrW-1:0]       rd_data,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [15:0]           overrun_cnt
`ifdef PEAK_DETECT_EN
   ,
   output logic [PwrW-1:0]       peak_pwr,
   output logic [IdxW-1:0]       peak_idx
`endif
);

   state_e                  state_q;
   logic [IdxW-1:0]         bin_idx_q;
   logic                    tready_q, wr_bank_q, frame_done_q, frame_err_q;
   logic [15:0]             overrun_q;
   logic                    s1_vld_q, s1_last_q, s2_vld_q, s2_last_q;
   logic [IdxW-1:0]         s1_idx_q, s2_idx_q;
   logic signed [ProdW-1:0] s1_rr_q, s1_ii_q;
   logic [PwrW-1:0]         s2_pwr_q;

   logic                    beat, last_bin, commit_now, commit_swap;
   logic signed [DOUT_W-1:0] re_s, im_s;

   assign re_s        = s_axis.m_tdata[DOUT_W-1:0];
   assign im_s        = s_axis.m_tdata[2*DOUT_W-1:DOUT_W];
   assign beat        = s_axis.m_tvalid && tready_q;
   assign last_bin    = (bin_idx_q == IdxW'(NPOINT - 1));
   // The good frame's last bin is written on the same edge the banks swap.
   assign commit_now  = (state_q == StCommit) && s2_last_q;
   assign commit_swap = commit_now && !rd_hold;

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q      <= StRun;
         bin_idx_q    <= '0;
         tready_q     <= 1'b0;
         wr_bank_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= '0;
      end else begin
         tready_q     <= 1'b1;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         if (beat) begin
            bin_idx_q <= bin_idx_q + IdxW'(1);
         end
         unique case (state_q)
            StRun: begin
               if (beat && last_bin) begin
                  if (s_axis.m_tlast) begin
                     state_q <= StCommit;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= StResync;
                  end
               end else if (beat && s_axis.m_tlast) begin
                  frame_err_q <= 1'b1;
                  bin_idx_q   <= '0;
               end
            end
            StResync: begin
               bin_idx_q <= '0;
               if (beat && s_axis.m_tlast) begin
                  state_q <= StRun;
               end
            end
            StCommit: begin
               // Beats here already belong to the next frame; a tlast this early is misaligned.
               if (beat && s_axis.m_tlast) begin
                  frame_err_q <= 1'b1;
                  bin_idx_q   <= '0;
               end
               if (commit_now) begin
                  if (commit_swap) begin
                     wr_bank_q    <= ~wr_bank_q;
                     frame_done_q <= 1'b1;
                  end else if (overrun_q != 16'hFFFF) begin
                     overrun_q <= overrun_q + 16'd1;
                  end
                  state_q <= StRun;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         s1_vld_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_idx_q  <= '0;
         s1_rr_q   <= '0;
         s1_ii_q   <= '0;
         s2_vld_q  <= 1'b0;
         s2_last_q <= 1'b0;
         s2_idx_q  <= '0;
         s2_pwr_q  <= '0;
      end else begin
         s1_vld_q  <= beat && (state_q != StResync);
         s1_last_q <= beat && (state_q == StRun) && last_bin && s_axis.m_tlast;
         s1_idx_q  <= bin_idx_q;
         s1_rr_q   <= ProdW'(re_s) * ProdW'(re_s);
         s1_ii_q   <= ProdW'(im_s) * ProdW'(im_s);
         s2_vld_q  <= s1_vld_q;
         s2_last_q <= s1_last_q;
         s2_idx_q  <= s1_idx_q;
         s2_pwr_q  <= PwrW'($unsigned(s1_rr_q)) + PwrW'($unsigned(s1_ii_q));
      end
   end

   spectrum_pingpong_ram #(
      .Depth (NPOINT),
      .Width (PwrW)
   ) u_ram (
      .clk_i     (sys_clk),
      .rst_ni    (sys_rstn),
      .wr_en_i   (s2_vld_q),
      .wr_bank_i (wr_bank_q),
      .wr_addr_i (s2_idx_q),
      .wr_data_i (s2_pwr_q),
      .rd_bank_i (~wr_bank_q),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   assign s_axis.m_tready = tready_q;
   assign frame_done      = frame_done_q;
   assign frame_err       = frame_err_q;
   assign overrun_cnt     = overrun_q;

`ifdef PEAK_DETECT_EN
   logic [PwrW-1:0] run_pwr_q, run_pwr_d, peak_pwr_q;
   logic [IdxW-1:0] run_idx_q, run_idx_d, peak_idx_q;

   // Bin 0 restarts tracking, so discarded partial frames never leak into the next peak.
   always_comb begin
      run_pwr_d = run_pwr_q;
      run_idx_d = run_idx_q;
      if (s2_vld_q && ((s2_idx_q == '0) || (s2_pwr_q > run_pwr_q))) begin
         run_pwr_d = s2_pwr_q;
         run_idx_d = s2_idx_q;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         run_pwr_q  <= '0;
         run_idx_q  <= '0;
         peak_pwr_q <= '0;
         peak_idx_q <= '0;
      end else begin
         run_pwr_q <= run_pwr_d;
         run_idx_q <= run_idx_d;
         if (commit_swap) begin
            peak_pwr_q <= run_pwr_d;
            peak_idx_q <= run_idx_d;
         end
      end
   end

   assign peak_pwr = peak_pwr_q;
   assign peak_idx = peak_idx_q;
`endif

endmodule

// File: tb/tb_fft_axis_to_spectrum.sv
// Randomized bench for fft_axis_to_spectrum with a frame-level reference model.
module tb_fft_axis_to_spectrum;
   import fft_spec_pkg::*;

   localparam int unsigned N = NPOINT_DEF;

   logic               sys_clk;
   logic               sys_rstn;
   logic               rd_hold;
   logic [IDX_W-1:0]   rd_addr;
   logic [PWR_W-1:0]   rd_data;
   logic               frame_done, frame_err;
   logic [15:0]        overrun_cnt;
`ifdef PEAK_DETECT_EN
   logic [PWR_W-1:0]   peak_pwr;
   logic [IDX_W-1:0]   peak_idx;
`endif

   fft_axis_to_spectrum_if #(.DOUT_W(DOUT_W_DEF)) bus ();

   fft_axis_to_spectrum dut (
      .sys_clk     (sys_clk),
      .sys_rstn    (sys_rstn),
      .s_axis      (bus),
      .rd_hold     (rd_hold),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .overrun_cnt (overrun_cnt)
`ifdef PEAK_DETECT_EN
      ,
      .peak_pwr    (peak_pwr),
      .peak_idx    (peak_idx)
`endif
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int err_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   logic [PWR_W-1:0] m_frame [N];
   logic [PWR_W-1:0] m_snap  [N];
   logic [PWR_W-1:0] m_pub   [N];
   int      m_cnt = 0;
   bit      m_resync = 0, m_ready = 0, m_pub_valid = 0, m_commit_pend = 0;
   longint  m_cyc = 0, m_commit_cyc = 0;
   bit      e_done = 0, e_err = 0, e_rd_chk = 1;
   int      e_ovr = 0;
   logic [PWR_W-1:0] e_rd = '0, e_peak_pwr = '0;
   int      e_peak_idx = 0;

   function automatic logic [PWR_W-1:0] power(input logic signed [DOUT_W_DEF-1:0] re,
                                             input logic signed [DOUT_W_DEF-1:0] im);
      longint r = re;
      longint i = im;
      return PWR_W'(r * r + i * i);
   endfunction

   always @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         m_cnt = 0; m_resync = 0; m_ready = 0; m_pub_valid = 0; m_commit_pend = 0;
         e_done = 0; e_err = 0; e_ovr = 0; e_rd = '0; e_rd_chk = 1;
         e_peak_pwr = '0; e_peak_idx = 0;
      end else begin
         m_cyc++;
         e_done = 0;
         e_err = 0;
         e_rd_chk = m_pub_valid;
         e_rd = m_pub[rd_addr];
         if (m_commit_pend && m_cyc == m_commit_cyc) begin
            m_commit_pend = 0;
            if (!rd_hold) begin
               m_pub = m_snap;
               m_pub_valid = 1;
               e_done = 1;
               e_peak_pwr = m_snap[0];
               e_peak_idx = 0;
               for (int i = 1; i < N; i++) begin
                  if (m_snap[i] > e_peak_pwr) begin
                     e_peak_pwr = m_snap[i];
                     e_peak_idx = i;
                  end
               end
            end else if (e_ovr < 65535) begin
               e_ovr++;
            end
         end
         if (m_ready && bus.m_tvalid) begin
            if (m_resync) begin
               if (bus.m_tlast) begin
                  m_resync = 0;
                  m_cnt = 0;
               end
            end else begin
               m_frame[m_cnt] = power(tdata_re(bus.m_tdata), tdata_im(bus.m_tdata));
               if (m_cnt == N - 1) begin
                  m_cnt = 0;
                  if (bus.m_tlast) begin
                     m_snap = m_frame;
                     m_commit_pend = 1;
                     m_commit_cyc = m_cyc + 2;
                  end else begin
                     e_err = 1;
                     m_resync = 1;
                  end
               end else if (bus.m_tlast) begin
                  e_err = 1;
                  m_cnt = 0;
               end else begin
                  m_cnt++;
               end
            end
         end
         m_ready = 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge sys_clk) begin
      chk("tready", bus.m_tready, m_ready);
      chk("frame_done", frame_done, e_done);
      chk("frame_err", frame_err, e_err);
      chk("overrun_cnt", overrun_cnt, e_ovr);
      if (e_rd_chk) chk("rd_data", rd_data, e_rd);
`ifdef PEAK_DETECT_EN
      chk("peak_pwr", peak_pwr, e_peak_pwr);
      chk("peak_idx", peak_idx, e_peak_idx);
`endif
      if (frame_done) done_seen++;
      if (frame_err) err_seen++;
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.m_tvalid = 1'b0;
         bus.m_tlast  = 1'b0;
         rd_addr      = IDX_W'($urandom);
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic drive_beat(input logic signed [15:0] re, input logic signed [15:0] im,
                             input logic last, input int gap_pct);
      while ($urandom_range(99) < gap_pct) idle(1);
      bus.m_tvalid = 1'b1;
      bus.m_tdata  = {im, re};
      bus.m_tlast  = last;
      rd_addr      = IDX_W'($urandom);
      @(posedge sys_clk);
      #1;
      bus.m_tvalid = 1'b0;
      bus.m_tlast  = 1'b0;
   endtask

   // mode 1: re=k,im=0  2: corner bins then random  3: re=k+5,im=1  4: re=-k,im=2  else random
   task automatic send(input int nbeats, input int last_at, input int mode, input int gap_pct);
      for (int k = 0; k < nbeats; k++) begin
         logic signed [15:0] re, im;
         re = 16'($urandom);
         im = 16'($urandom);
         case (mode)
            1: begin re = 16'(k); im = 16'sd0; end
            2: begin
               if (k == 0) begin re = -16'sd32768; im = -16'sd32768; end
               if (k == 1) begin re = 16'sd3; im = -16'sd4; end
            end
            3: begin re = 16'(k + 5); im = 16'sd1; end
            4: begin re = -16'(k); im = 16'sd2; end
            default: ;
         endcase
         drive_beat(re, im, k == last_at, gap_pct);
      end
   endtask

   task automatic read_chk(input int addr, input logic [PWR_W-1:0] exp, input string name);
      rd_addr = IDX_W'(addr);
      @(posedge sys_clk);
      #1;
      chk(name, rd_data, exp);
   endtask

   initial begin
      sys_rstn = 1'b0;
      rd_hold = 1'b0;
      rd_addr = '0;
      bus.m_tvalid = 1'b0;
      bus.m_tlast = 1'b0;
      bus.m_tdata = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_tready", bus.m_tready, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_overrun", overrun_cnt, 0);
      sys_rstn = 1'b1;
      idle(2);
      chk("tready_up", bus.m_tready, 1);

      // 1: ramp frame, power k^2
      send(N, N - 1, 1, 0);
      idle(6);
      chk("t1_done", done_seen, 1);
      chk("t1_err", err_seen, 0);
      read_chk(0, 0, "t1_bin0");
      read_chk(7, 49, "t1_bin7");
      read_chk(500, 250000, "t1_bin500");
      read_chk(1023, 1023 * 1023, "t1_bin1023");
`ifdef PEAK_DETECT_EN
      chk("t1_peak_pwr", peak_pwr, 1023 * 1023);
      chk("t1_peak_idx", peak_idx, 1023);
`endif

      // 2: extreme and mixed-sign bins
      send(N, N - 1, 2, 30);
      idle(6);
      chk("t2_done", done_seen, 2);
      read_chk(0, 33'h0_8000_0000, "t2_extreme");
      read_chk(1, 25, "t2_3_m4");
`ifdef PEAK_DETECT_EN
      chk("t2_peak_idx", peak_idx, 0);
`endif

      // 3: early tlast, then a clean frame must start at bin 0
      send(501, 500, 0, 20);
      idle(4);
      chk("t3_err", err_seen, 1);
      chk("t3_no_done", done_seen, 2);
      send(N, N - 1, 3, 0);
      idle(6);
      chk("t3_done", done_seen, 3);
      read_chk(0, 26, "t3_bin0");
      read_chk(1023, 1028 * 1028 + 1, "t3_bin1023");

      // 4: late tlast, ten extra beats dropped
      send(N + 10, N + 9, 0, 10);
      idle(4);
      chk("t4_err", err_seen, 2);
      chk("t4_no_done", done_seen, 3);
      send(N, N - 1, 4, 20);
      idle(6);
      chk("t4_done", done_seen, 4);
      read_chk(1023, 1023 * 1023 + 4, "t4_bin1023");

      // 5: reader holds across two good frames
      rd_hold = 1'b1;
      send(N, N - 1, 0, 0);
      send(N, N - 1, 0, 10);
      idle(6);
      chk("t5_overrun", overrun_cnt, 2);
      chk("t5_no_done", done_seen, 4);
      read_chk(1023, 1023 * 1023 + 4, "t5_held_bin1023");
      read_chk(5, 25 + 4, "t5_held_bin5");
      rd_hold = 1'b0;
      send(N, N - 1, 1, 0);
      idle(6);
      chk("t5_done", done_seen, 5);
      read_chk(3, 9, "t5_bin3");

      // 6: reset in the middle of a gappy frame
      send(600, -1, 0, 50);
      sys_rstn = 1'b0;
      @(posedge sys_clk);
      #1;
      chk("t6_rst_tready", bus.m_tready, 0);
      chk("t6_rst_overrun", overrun_cnt, 0);
      chk("t6_rst_rd_data", rd_data, 0);
      chk("t6_rst_done", frame_done, 0);
      chk("t6_rst_err", frame_err, 0);
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rstn = 1'b1;
      idle(4);
      chk("t6_quiet_done", done_seen, 5);
      send(N, N - 1, 0, 50);
      idle(6);
      chk("t6_done", done_seen, 6);
      chk("t6_err", err_seen, 2);
      for (int i = 0; i < 8; i++) idle(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
